// File: rtl/seven_seg_scanner_if.sv
// Load handshake bundle for seven_seg_scanner: a new 16-bit value plus decimal points.
// The source drives the master side and the scanner drives the slave side.
interface seven_seg_scanner_if;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_dp;

  modport master (output load_valid, output load_data, output load_dp, input load_ready);
  modport slave  (input load_valid, input load_data, input load_dp, output load_ready);
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment display.
// Loaded values wait in a pending buffer and reach the display only at frame boundaries.
module seven_seg_scanner #(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  seven_seg_scanner_if.slave load,
  output logic [3:0]        anode,
  output logic [6:0]        segs,
  output logic              dp,
  output logic              frame_done
);

  localparam int            CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [1:0]    idx_r;
  logic [15:0]   disp_r;
  logic [3:0]    dp_reg_r;
  logic [15:0]   pend_data_r;
  logic [3:0]    pend_dp_r;
  logic          pend_valid_r;
  logic [3:0]    anode_r;
  logic [6:0]    segs_r;
  logic          dp_r;
  logic          frame_done_r;
  logic [3:0]    nibble_s;
  logic [6:0]    segs_s;
  logic          commit_s;

  function automatic logic [6:0] hex_to_segs(input logic [3:0] nib);
    case (nib)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h3:    return 7'b0110000;
      4'h4:    return 7'b0011001;
      4'h5:    return 7'b0010010;
      4'h6:    return 7'b0000010;
      4'h7:    return 7'b1111000;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0010000;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b0000011;
      4'hC:    return 7'b1000110;
      4'hD:    return 7'b0100001;
      4'hE:    return 7'b0000110;
      4'hF:    return 7'b0001110;
      default: return 7'b1111111;
    endcase
  endfunction

  // Digit k is a leading zero when its nibble and every higher nibble are zero.
  function automatic logic leading_zero(input logic [15:0] value, input logic [1:0] k);
    case (k)
      2'd1:    return (value[15:4] == 12'd0);
      2'd2:    return (value[15:8] == 8'd0);
      2'd3:    return (value[15:12] == 4'd0);
      default: return 1'b0;
    endcase
  endfunction

  assign nibble_s = disp_r[{idx_r, 2'b00} +: 4];
  assign segs_s   = (BLANK_LEADING && leading_zero(disp_r, idx_r)) ? 7'b1111111
                                                                    : hex_to_segs(nibble_s);
  assign commit_s = pend_valid_r &&
                    (!enable || ((cnt_r == CNT_LAST) && (idx_r == 2'd3)));

  assign load.load_ready = ~pend_valid_r;
  assign anode           = anode_r;
  assign segs            = segs_r;
  assign dp              = dp_r;
  assign frame_done      = frame_done_r;

  // Scan FSM, pending-buffer handshake and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      idx_r        <= 2'd0;
      disp_r       <= 16'd0;
      dp_reg_r     <= 4'd0;
      pend_data_r  <= 16'd0;
      pend_dp_r    <= 4'd0;
      pend_valid_r <= 1'b0;
      anode_r      <= 4'b1111;
      segs_r       <= 7'b1111111;
      dp_r         <= 1'b1;
      frame_done_r <= 1'b0;
    end else begin
      // A value captured on a commit cycle waits for the next boundary.
      if (pend_valid_r) begin
        if (commit_s) begin
          disp_r       <= pend_data_r;
          dp_reg_r     <= pend_dp_r;
          pend_valid_r <= 1'b0;
        end
      end else if (load.load_valid) begin
        pend_data_r  <= load.load_data;
        pend_dp_r    <= load.load_dp;
        pend_valid_r <= 1'b1;
      end

      if (enable) begin
        state_r      <= SCAN;
        anode_r      <= ~(4'b0001 << idx_r);
        segs_r       <= segs_s;
        dp_r         <= ~dp_reg_r[idx_r];
        frame_done_r <= (state_r == SCAN) && (idx_r == 2'd0) && (cnt_r == '0);
        if (cnt_r == CNT_LAST) begin
          cnt_r <= '0;
          idx_r <= idx_r + 2'd1;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        state_r      <= IDLE;
        cnt_r        <= '0;
        idx_r        <= 2'd0;
        anode_r      <= 4'b1111;
        segs_r       <= 7'b1111111;
        dp_r         <= 1'b1;
        frame_done_r <= 1'b0;
      end
    end
  end

endmodule
